// File: rtl/rrf_flag_retire_pkg.sv
// Shared definitions for the flag retire-group collector: default sizes
// and the group FSM state encoding.
package rrf_flag_retire_pkg;

    localparam int DEFAULT_SLOTS      = 4;
    localparam int DEFAULT_DATA_WIDTH = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/rrf_flag_retire_sel.sv
// Youngest flag-writer select within one retire chunk: the highest-index
// slot that is both valid and writes flags provides the chunk's flags.
module rrf_flag_retire_sel
    import rrf_flag_retire_pkg::*;
#(
    parameter int SLOTS      = DEFAULT_SLOTS,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [SLOTS-1:0]            valid_i,
    input  logic [SLOTS-1:0]            flagWen_i,
    input  logic [SLOTS*DATA_WIDTH-1:0] flags_i,
    output logic                        selValid_o,
    output logic [DATA_WIDTH-1:0]       selFlags_o
);

    // Walk slots oldest to youngest so the last match (youngest) wins
    always_comb begin
        selValid_o = 1'b0;
        selFlags_o = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (valid_i[i] && flagWen_i[i]) begin
                selValid_o = 1'b1;
                selFlags_o = flags_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/rrf_flag_retire.sv
// Flag retire collector: accumulates the youngest flag writer across the
// chunks of a retire group and issues one RRF flag write when the group
// closes. Optional macro RRF_FLAG_FWD_EN adds fwd_data/fwd_valid, which
// expose the pending flags of an open group for early rename recovery.
module rrf_flag_retire
    import rrf_flag_retire_pkg::*;
#(
    parameter int SLOTS      = DEFAULT_SLOTS,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SLOTS-1:0]            ret_valid,
    input  logic [SLOTS-1:0]            ret_flagWen,
    input  logic [SLOTS*DATA_WIDTH-1:0] ret_flags,
    input  logic                        ret_thread,
    input  logic                        ret_last,
    input  logic                        ret_cancel,
    output logic [DATA_WIDTH-1:0]       write0_data,
    output logic                        write0_wen,
    output logic                        write_thread,
    output logic                        busy,
    output logic                        thr_err
`ifdef RRF_FLAG_FWD_EN
    ,
    output logic [DATA_WIDTH-1:0]       fwd_data,
    output logic                        fwd_valid
`endif
);

    state_e                  state_q;
    logic                    pendV_q;
    logic [DATA_WIDTH-1:0]   pendFlags_q;
    logic                    groupThr_q;
    logic                    wen_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    wthr_q;
    logic                    thrErr_q;

    logic                    selValid;
    logic [DATA_WIDTH-1:0]   selFlags;
    logic                    chunk;
    logic                    inAccum;
    logic                    pendV_d;
    logic [DATA_WIDTH-1:0]   pendFlags_d;
    logic                    closeThr;

    rrf_flag_retire_sel #(
        .SLOTS      (SLOTS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sel (
        .valid_i    (ret_valid),
        .flagWen_i  (ret_flagWen),
        .flags_i    (ret_flags),
        .selValid_o (selValid),
        .selFlags_o (selFlags)
    );

    assign chunk   = (|ret_valid) || ret_last;
    assign inAccum = (state_q == ACCUM);

    // Merge this chunk's writer over what the open group already holds
    assign pendV_d     = selValid || (inAccum && pendV_q);
    assign pendFlags_d = selValid ? selFlags :
                         ((inAccum && pendV_q) ? pendFlags_q : '0);
    assign closeThr    = inAccum ? groupThr_q : ret_thread;

    // Group FSM with registered write port; cancel outranks close
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            pendV_q     <= 1'b0;
            pendFlags_q <= '0;
            groupThr_q  <= 1'b0;
            wen_q       <= 1'b0;
            data_q      <= '0;
            wthr_q      <= 1'b0;
            thrErr_q    <= 1'b0;
        end else begin
            wen_q <= 1'b0;
            if (ret_cancel) begin
                state_q     <= IDLE;
                pendV_q     <= 1'b0;
                pendFlags_q <= '0;
            end else if (chunk) begin
                if (ret_last) begin
                    state_q     <= IDLE;
                    pendV_q     <= 1'b0;
                    pendFlags_q <= '0;
                    if (pendV_d) begin
                        wen_q  <= 1'b1;
                        data_q <= pendFlags_d;
                        wthr_q <= closeThr;
                    end
                end else begin
                    state_q     <= ACCUM;
                    pendV_q     <= pendV_d;
                    pendFlags_q <= pendFlags_d;
                end
                if (!inAccum) begin
                    groupThr_q <= ret_thread;
                end else if (ret_thread != groupThr_q) begin
                    thrErr_q <= 1'b1;
                end
            end
        end
    end

    assign write0_data  = data_q;
    assign write0_wen   = wen_q;
    assign write_thread = wthr_q;
    assign busy         = inAccum;
    assign thr_err      = thrErr_q;

`ifdef RRF_FLAG_FWD_EN
    assign fwd_valid = inAccum && pendV_q;
    assign fwd_data  = (inAccum && pendV_q) ? pendFlags_q : '0;
`else
    // Forwarding ports are not present in this build
`endif

endmodule

// File: tb/tb_rrf_flag_retire.sv
// Self-checking bench for rrf_flag_retire: writes are predicted into a
// scoreboard when the closing chunk is driven and matched as they appear.
module tb_rrf_flag_retire;

    localparam int SLOTS = 4;
    localparam int DW    = 6;

    typedef struct {
        logic [DW-1:0] data;
        logic          thr;
        int            cyc;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic [SLOTS-1:0]      retValid;
    logic [SLOTS-1:0]      retFlagWen;
    logic [SLOTS*DW-1:0]   retFlags;
    logic                  retThread;
    logic                  retLast;
    logic                  retCancel;
    logic [DW-1:0]         write0Data;
    logic                  write0Wen;
    logic                  writeThread;
    logic                  busy;
    logic                  thrErr;
`ifdef RRF_FLAG_FWD_EN
    logic [DW-1:0]         fwdData;
    logic                  fwdValid;
`endif

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t expQ[$];

    rrf_flag_retire #(
        .SLOTS      (SLOTS),
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ret_valid    (retValid),
        .ret_flagWen  (retFlagWen),
        .ret_flags    (retFlags),
        .ret_thread   (retThread),
        .ret_last     (retLast),
        .ret_cancel   (retCancel),
        .write0_data  (write0Data),
        .write0_wen   (write0Wen),
        .write_thread (writeThread),
        .busy         (busy),
        .thr_err      (thrErr)
`ifdef RRF_FLAG_FWD_EN
        ,
        .fwd_data     (fwdData),
        .fwd_valid    (fwdValid)
`endif
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle stamp used to check the one-cycle close-to-write latency
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every write must match the oldest prediction on time
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            if (write0Wen) begin
                if (expQ.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL unexpected_write: got data=%h thr=%0d, wanted no write", write0Data, writeThread);
                end else begin
                    e = expQ.pop_front();
                    total++;
                    if (write0Data !== e.data) begin
                        bad++;
                        $display("[TB] FAIL write_data: got %h, wanted %h", write0Data, e.data);
                    end
                    total++;
                    if (writeThread !== e.thr) begin
                        bad++;
                        $display("[TB] FAIL write_thread: got %0d, wanted %0d", writeThread, e.thr);
                    end
                    total++;
                    if (cyc !== e.cyc) begin
                        bad++;
                        $display("[TB] FAIL write_cycle: got %0d, wanted %0d", cyc, e.cyc);
                    end
                end
            end else if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
                e = expQ.pop_front();
                total++; bad++;
                $display("[TB] FAIL missing_write: got no write at cycle %0d, wanted data=%h", cyc, e.data);
            end
        end
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, wanted test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [SLOTS*DW-1:0] pack(input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                                                 input logic [DW-1:0] s2, input logic [DW-1:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    function automatic logic [DW:0] youngest(input logic [SLOTS-1:0] v, input logic [SLOTS-1:0] w,
                                             input logic [SLOTS*DW-1:0] f);
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (v[i] && w[i]) return {1'b1, f[i*DW +: DW]};
        end
        return '0;
    endfunction

    task automatic pushExp(input logic [DW-1:0] d, input logic t);
        exp_t e;
        e.data = d;
        e.thr  = t;
        e.cyc  = cyc + 1;
        expQ.push_back(e);
    endtask

    task automatic drive(input logic [SLOTS-1:0] v, input logic [SLOTS-1:0] w, input logic [SLOTS*DW-1:0] f,
                         input logic thr, input logic last, input logic cancel);
        retValid   = v;
        retFlagWen = w;
        retFlags   = f;
        retThread  = thr;
        retLast    = last;
        retCancel  = cancel;
        @(negedge clk);
    endtask

    task automatic idle();
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (write0Wen !== 1'b0) begin bad++; $display("[TB] FAIL reset_wen: got %b, wanted 0", write0Wen); end
        total++; if (write0Data !== 6'h00) begin bad++; $display("[TB] FAIL reset_data: got %h, wanted 00", write0Data); end
        total++; if (writeThread !== 1'b0) begin bad++; $display("[TB] FAIL reset_thread: got %b, wanted 0", writeThread); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b, wanted 0", busy); end
        total++; if (thrErr !== 1'b0) begin bad++; $display("[TB] FAIL reset_thr_err: got %b, wanted 0", thrErr); end
        rst = 1'b1;
    endtask

    task automatic test_single_chunk();
        pushExp(6'h2A, 1'b1);
        drive(4'b1111, 4'b0101, pack(6'h05, 6'h13, 6'h2A, 6'h31), 1'b1, 1'b1, 1'b0);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy: got %b, wanted 0", busy); end
        idle();
        total++; if (write0Wen !== 1'b0) begin bad++; $display("[TB] FAIL single_wen_pulse: got %b, wanted 0", write0Wen); end
        total++; if (write0Data !== 6'h2A) begin bad++; $display("[TB] FAIL data_hold: got %h, wanted 2a", write0Data); end
    endtask

    task automatic test_multi_chunk();
        drive(4'b0001, 4'b0001, pack(6'h11, 6'h00, 6'h00, 6'h00), 1'b0, 1'b0, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL multi_busy1: got %b, wanted 1", busy); end
        drive(4'b0011, 4'b0000, pack(6'h3E, 6'h01, 6'h00, 6'h00), 1'b0, 1'b0, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL multi_busy2: got %b, wanted 1", busy); end
        pushExp(6'h07, 1'b0);
        drive(4'b1000, 4'b1000, pack(6'h00, 6'h00, 6'h00, 6'h07), 1'b0, 1'b1, 1'b0);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL multi_busy3: got %b, wanted 0", busy); end
        idle();
        idle();
    endtask

    task automatic test_cancel();
        drive(4'b0001, 4'b0001, pack(6'h3F, 6'h00, 6'h00, 6'h00), 1'b1, 1'b0, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL cancel_open: got %b, wanted 1", busy); end
        drive(4'b0001, 4'b0000, pack(6'h00, 6'h00, 6'h00, 6'h00), 1'b1, 1'b1, 1'b1);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL cancel_busy: got %b, wanted 0", busy); end
        total++; if (write0Wen !== 1'b0) begin bad++; $display("[TB] FAIL cancel_wen: got %b, wanted 0", write0Wen); end
        idle();
        total++; if (write0Wen !== 1'b0) begin bad++; $display("[TB] FAIL cancel_late_wen: got %b, wanted 0", write0Wen); end
        pushExp(6'h21, 1'b0);
        drive(4'b0010, 4'b0010, pack(6'h00, 6'h21, 6'h00, 6'h00), 1'b0, 1'b1, 1'b0);
        drive('0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle();
    endtask

    task automatic test_thread_mismatch();
        drive(4'b0001, 4'b0001, pack(6'h09, 6'h00, 6'h00, 6'h00), 1'b0, 1'b0, 1'b0);
        total++; if (thrErr !== 1'b0) begin bad++; $display("[TB] FAIL thr_err_early: got %b, wanted 0", thrErr); end
        pushExp(6'h12, 1'b0);
        drive(4'b0100, 4'b0100, pack(6'h00, 6'h00, 6'h12, 6'h00), 1'b1, 1'b1, 1'b0);
        total++; if (thrErr !== 1'b1) begin bad++; $display("[TB] FAIL thr_err_set: got %b, wanted 1", thrErr); end
        idle();
        idle();
        total++; if (thrErr !== 1'b1) begin bad++; $display("[TB] FAIL thr_err_sticky: got %b, wanted 1", thrErr); end
    endtask

    task automatic test_reset_mid_group();
        pushExp(6'h2B, 1'b1);
        drive(4'b0001, 4'b0001, pack(6'h2B, 6'h00, 6'h00, 6'h00), 1'b1, 1'b1, 1'b0);
        drive(4'b0001, 4'b0001, pack(6'h15, 6'h00, 6'h00, 6'h00), 1'b0, 1'b0, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_open: got %b, wanted 1", busy); end
        rst = 1'b0;
        idle();
        total++; if (write0Wen !== 1'b0) begin bad++; $display("[TB] FAIL mid_wen: got %b, wanted 0", write0Wen); end
        total++; if (write0Data !== 6'h00) begin bad++; $display("[TB] FAIL mid_data: got %h, wanted 00", write0Data); end
        total++; if (writeThread !== 1'b0) begin bad++; $display("[TB] FAIL mid_thread: got %b, wanted 0", writeThread); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy: got %b, wanted 0", busy); end
        total++; if (thrErr !== 1'b0) begin bad++; $display("[TB] FAIL mid_thr_err: got %b, wanted 0", thrErr); end
        rst = 1'b1;
        drive(4'b0011, 4'b0000, pack(6'h1C, 6'h2D, 6'h00, 6'h00), 1'b1, 1'b0, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_accept: got %b, wanted 1", busy); end
        drive(4'b0001, 4'b0000, pack(6'h3A, 6'h00, 6'h00, 6'h00), 1'b1, 1'b1, 1'b0);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_close: got %b, wanted 0", busy); end
        idle();
        idle();
    endtask

    task automatic test_back_to_back();
        logic [SLOTS-1:0]    v, w;
        logic [SLOTS*DW-1:0] f;
        logic                t;
        logic [DW:0]         y;
        for (int i = 0; i < 16; i++) begin
            v = SLOTS'($urandom);
            w = SLOTS'($urandom);
            f = (SLOTS*DW)'($urandom);
            t = 1'($urandom);
            if (i == 0) begin v = 4'b1111; w = 4'b1111; end
            y = youngest(v, w, f);
            if (y[DW]) pushExp(y[DW-1:0], t);
            drive(v, w, f, t, 1'b1, 1'b0);
        end
        drive(4'b0001, 4'b0001, pack(6'h0A, 6'h00, 6'h00, 6'h00), 1'b0, 1'b0, 1'b0);
        pushExp(6'h0B, 1'b0);
        drive(4'b0010, 4'b0010, pack(6'h00, 6'h0B, 6'h00, 6'h00), 1'b0, 1'b1, 1'b0);
        pushExp(6'h0D, 1'b1);
        drive(4'b0100, 4'b0100, pack(6'h00, 6'h00, 6'h0D, 6'h00), 1'b1, 1'b1, 1'b0);
        idle();
        idle();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_busy: got %b, wanted 0", busy); end
    endtask

`ifdef RRF_FLAG_FWD_EN
    task automatic test_forward();
        drive(4'b0001, 4'b0000, pack(6'h00, 6'h00, 6'h00, 6'h00), 1'b0, 1'b0, 1'b0);
        total++; if (fwdValid !== 1'b0) begin bad++; $display("[TB] FAIL fwd_nopend: got %b, wanted 0", fwdValid); end
        drive(4'b0010, 4'b0010, pack(6'h00, 6'h0C, 6'h00, 6'h00), 1'b0, 1'b0, 1'b0);
        total++; if (fwdValid !== 1'b1) begin bad++; $display("[TB] FAIL fwd_valid: got %b, wanted 1", fwdValid); end
        total++; if (fwdData !== 6'h0C) begin bad++; $display("[TB] FAIL fwd_data: got %h, wanted 0c", fwdData); end
        pushExp(6'h0C, 1'b0);
        drive(4'b0001, 4'b0000, pack(6'h00, 6'h00, 6'h00, 6'h00), 1'b0, 1'b1, 1'b0);
        total++; if (fwdValid !== 1'b0) begin bad++; $display("[TB] FAIL fwd_closed: got %b, wanted 0", fwdValid); end
        total++; if (fwdData !== 6'h00) begin bad++; $display("[TB] FAIL fwd_closed_data: got %h, wanted 00", fwdData); end
        idle();
    endtask
`endif

    // Test sequence; each scenario starts and ends on a falling edge
    initial begin
        rst        = 1'b0;
        retValid   = '0;
        retFlagWen = '0;
        retFlags   = '0;
        retThread  = 1'b0;
        retLast    = 1'b0;
        retCancel  = 1'b0;
        test_reset();
        test_single_chunk();
        test_multi_chunk();
        test_cancel();
        test_thread_mismatch();
        test_reset_mid_group();
        test_back_to_back();
`ifdef RRF_FLAG_FWD_EN
        test_forward();
`endif
        repeat (3) idle();
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, wanted 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rrf_flag_retire.md
RRF_FLAG_RETIRE -- requirements
Module: rrf_flag_retire

Interface
REQ-001 SHALL have parameter SLOTS, default 4, meaning retire slots per chunk.
REQ-002 SHALL have parameter DATA_WIDTH, default 6, meaning flag word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port ret_valid, input, SLOTS bits: per-slot retire valid.
REQ-006 SHALL have port ret_flagWen, input, SLOTS bits: per-slot flag-write flag.
REQ-007 SHALL have port ret_flags, input, SLOTS*DATA_WIDTH bits: slot i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port ret_thread, input, 1 bit: thread of the chunk.
REQ-009 SHALL have port ret_last, input, 1 bit: the chunk closes the retire group.
REQ-010 SHALL have port ret_cancel, input, 1 bit: flush the open group.
REQ-011 SHALL have port write0_data, output, DATA_WIDTH bits: to the flag RRF write port.
REQ-012 SHALL have port write0_wen, output, 1 bit: to the flag RRF write port.
REQ-013 SHALL have port write_thread, output, 1 bit: to the flag RRF write port.
REQ-014 SHALL have port busy, output, 1 bit: a group is open.
REQ-015 SHALL have port thr_err, output, 1 bit: sticky thread-mismatch flag.

Function
REQ-016 A chunk SHALL be any cycle with |ret_valid or ret_last.
REQ-017 In-chunk selection SHALL take the highest-index slot with ret_valid&ret_flagWen as youngest; no such slot means the chunk carries no flags.
REQ-018 The FSM SHALL have states IDLE and ACCUM.
REQ-019 IDLE with a chunk and !ret_last SHALL go to ACCUM, latch the group thread from ret_thread, and latch the selected flags with pend_v.
REQ-020 In ACCUM, a chunk with a flag writer SHALL overwrite the pending flags (youngest wins); a chunk with no writer SHALL keep them.
REQ-021 A chunk with ret_last SHALL close the group and return the FSM to IDLE; a single-chunk group closes directly from IDLE.
REQ-022 On close with a pending or same-chunk flag writer, write0_wen SHALL be 1 for exactly one cycle, one cycle after the closing chunk, with the youngest flags and the group thread; otherwise write0_wen stays 0.
REQ-023 ret_cancel SHALL drop the pending flags and go to IDLE; no write results.
REQ-024 ret_cancel SHALL win over ret_last in the same cycle.
REQ-025 ret_cancel SHALL NOT suppress a write already registered from the previous cycle.
REQ-026 A chunk in ACCUM whose ret_thread differs from the group thread SHALL set thr_err until reset; its flags are still accepted and the group thread is unchanged.
REQ-027 busy SHALL be 1 exactly in ACCUM.
REQ-028 Back-to-back groups SHALL sustain one close per cycle with no bubble.
REQ-029 write0_data SHALL hold its value when write0_wen is 0.

Reset
REQ-030 While rst=0 at a clock edge, the block SHALL set state IDLE, pend_v=0, pending flags 0, write0_wen=0, write0_data=0, write_thread=0, thr_err=0 and busy=0.
REQ-031 A reset that arrives with a group open SHALL discard the group, and no write SHALL follow.
REQ-032 After reset the block SHALL accept chunks from the first cycle with rst=1.

Configuration
REQ-033 With macro RRF_FLAG_FWD_EN defined, the block SHALL add outputs fwd_data (DATA_WIDTH bits) and fwd_valid (1 bit).
REQ-034 fwd_data/fwd_valid SHALL combinationally show the pending youngest flags while in ACCUM with pend_v, else 0/0, for early rename-table recovery.
REQ-035 Without RRF_FLAG_FWD_EN the ports SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-036 A shared package SHALL hold the default DATA_WIDTH, the default SLOTS and the FSM state enum (IDLE, ACCUM).
REQ-037 The youngest-writer priority select SHALL be a sub-module rrf_flag_retire_sel; it is combinational and parameterised by SLOTS and DATA_WIDTH.
REQ-038 All registers SHALL be in the top module.

Verification
REQ-039 Single chunk: valid=1111, flagWen=0101, slot0=0x05, slot2=0x2A, last=1, thread=1 -> next cycle write0_wen=1, data=0x2A, write_thread=1.
REQ-040 Three chunks with flags 0x11, none, 0x07, last on the third -> busy=1 for two cycles, then a single write with data 0x07.
REQ-041 Open group with pending 0x3F, then cancel and last in the same cycle -> no write, IDLE, busy=0.
REQ-042 Thread 0 group, second chunk with thread=1 -> thr_err=1 and stays 1; the write carries write_thread=0.
REQ-043 rst=0 while ACCUM holds 0x15 -> all outputs 0; after release, a group with no flag writer -> no write.
REQ-044 With RRF_FLAG_FWD_EN: pending 0x0C in ACCUM -> fwd_valid=1, fwd_data=0x0C; after close -> fwd_valid=0.
